// File: rtl/muldiv_seq_pkg.sv
// Purpose : shared types for the M-extension sequencer (word_t, muldiv_op_t, control_t) plus op-decode helpers.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package muldiv_seq_pkg;

    localparam int XLEN = 64;
    localparam int WLEN = 32;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [2*XLEN-1:0] dword_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    // Decoded execute-stage control; muldiv_sel steers the result mux from the ALU to the sequencer.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       muldiv_sel;
        muldiv_op_t muldiv_op;
        logic       muldiv_word;
    } control_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    // MUL is treated as signed x signed: the low half is identical either way.
    function automatic logic op_a_signed(input muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Purpose : execute <-> sequencer bundle (issue handshake, flush, result handshake, stall).
// Latency : n/a (wires only).
// Backpressure: issue via in_valid/in_ready, result via out_valid/out_ready.
// master = execute stage, slave = muldiv_seq.
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
();
    logic       in_valid;
    logic       in_ready;
    muldiv_op_t in_op;
    logic       in_word;
    word_t      in_a;
    word_t      in_b;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    logic       stall;

    modport master (
        output in_valid, in_op, in_word, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_data, stall
    );

    modport slave (
        input  in_valid, in_op, in_word, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_data, stall
    );
endinterface

// File: rtl/muldiv_seq_signfix.sv
// Purpose : combinational sign handling: operand W-extension + magnitude, result negation + W sign-extension.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_a/i_b + signedness -> o_*_ext (extended value), o_*_mag, o_*_neg;
//        i_res + i_res_neg -> o_res (negated if asked, then W-form sign-extended).
module muldiv_seq_signfix
    import muldiv_seq_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  logic  i_word,
    input  logic  i_a_signed,
    input  logic  i_b_signed,
    output word_t o_a_ext,
    output word_t o_b_ext,
    output word_t o_a_mag,
    output word_t o_b_mag,
    output logic  o_a_neg,
    output logic  o_b_neg,
    input  word_t i_res,
    input  logic  i_res_neg,
    output word_t o_res
);
    function automatic word_t ext_w(input logic [WLEN-1:0] v, input logic sgn);
        return {{(XLEN-WLEN){sgn & v[WLEN-1]}}, v};
    endfunction

    word_t w_res_n;

    assign o_a_ext = i_word ? ext_w(i_a[WLEN-1:0], i_a_signed) : i_a;
    assign o_b_ext = i_word ? ext_w(i_b[WLEN-1:0], i_b_signed) : i_b;

    assign o_a_neg = i_a_signed & o_a_ext[XLEN-1];
    assign o_b_neg = i_b_signed & o_b_ext[XLEN-1];

    // Most-negative input maps onto itself, which read as unsigned is the correct magnitude.
    assign o_a_mag = o_a_neg ? -o_a_ext : o_a_ext;
    assign o_b_mag = o_b_neg ? -o_b_ext : o_b_ext;

    // Negate first, then sign-extend bit 31, so that -(0x8000_0000) stays 0xFFFF_FFFF_8000_0000.
    assign w_res_n = i_res_neg ? -i_res : i_res;
    assign o_res   = i_word ? ext_w(w_res_n[WLEN-1:0], 1'b1) : w_res_n;

endmodule

// File: rtl/muldiv_seq.sv
// Purpose : radix-2 multi-cycle RV64M multiply/divide sequencer beside the execute ALU.
// Latency : accept edge + N edges (N=64, 32 for W forms); div-by-zero / signed overflow done on the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush discards at any state.
// Ports: clk, reset (async, active-low), bus (muldiv_seq_if.slave: in_* issue, flush, out_* result, stall).
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] r_state;
    logic [5:0] r_cnt;
    muldiv_op_t r_op;
    logic       r_word;
    logic       r_neg;
    word_t      r_mag_a;
    word_t      r_mag_b;
    dword_t     r_acc;
    word_t      r_out_data;

    logic   w_idle;
    logic   w_calc;
    logic   w_done;
    word_t  w_a_ext;
    word_t  w_b_ext;
    word_t  w_a_mag;
    word_t  w_b_mag;
    logic   w_a_neg;
    logic   w_b_neg;
    logic   w_in_div;
    logic   w_b_zero;
    logic   w_ovf;
    logic   w_special;
    word_t  w_min_neg;
    word_t  w_spec_raw;
    logic   w_neg_in;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;
    logic   w_ge;
    dword_t w_acc_nxt;
    word_t  w_hi;
    word_t  w_lo;
    word_t  w_fin_raw;
    word_t  w_fix_in;
    logic   w_fix_neg;
    logic   w_fix_word;
    word_t  w_fix_out;

    assign w_idle = (r_state == S_IDLE);
    assign w_calc = (r_state == S_CALC);
    assign w_done = (r_state == S_DONE);

    // One signfix instance: operand prep while IDLE, result finish otherwise.
    assign w_fix_word = w_idle ? bus.in_word : r_word;
    assign w_fix_in   = w_calc ? w_fin_raw : w_spec_raw;
    assign w_fix_neg  = w_calc & r_neg;

    muldiv_seq_signfix u_signfix (
        .i_a        (bus.in_a),
        .i_b        (bus.in_b),
        .i_word     (w_fix_word),
        .i_a_signed (op_a_signed(bus.in_op)),
        .i_b_signed (op_b_signed(bus.in_op)),
        .o_a_ext    (w_a_ext),
        .o_b_ext    (w_b_ext),
        .o_a_mag    (w_a_mag),
        .o_b_mag    (w_b_mag),
        .o_a_neg    (w_a_neg),
        .o_b_neg    (w_b_neg),
        .i_res      (w_fix_in),
        .i_res_neg  (w_fix_neg),
        .o_res      (w_fix_out)
    );

    // Special divides resolve without iterating; results are built from the extended dividend.
    assign w_in_div   = op_is_div(bus.in_op);
    assign w_b_zero   = (w_b_ext == '0);
    assign w_min_neg  = bus.in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_ovf      = w_in_div & op_a_signed(bus.in_op) & (w_a_ext == w_min_neg) & (w_b_ext == '1);
    assign w_special  = w_in_div & (w_b_zero | w_ovf);
    assign w_spec_raw = op_is_rem(bus.in_op) ? (w_b_zero ? w_a_ext : '0)
                                             : (w_b_zero ? '1      : w_a_ext);

    // Remainder follows the dividend; product and quotient negate when the signs differ.
    assign w_neg_in = op_is_rem(bus.in_op) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // One radix-2 step; operand bits are consumed MSB-first at index r_cnt.
    // Divide packs {remainder, quotient} into r_acc; the partial remainder stays below the divisor.
    assign w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_mag_a[r_cnt]};
    assign w_diff   = w_rem_sh - {1'b0, r_mag_b};
    assign w_ge     = ~w_diff[XLEN];

    always_comb begin
        w_acc_nxt = r_acc;
        if (op_is_div(r_op)) begin
            w_acc_nxt = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
        end else begin
            w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0}
                      + (r_mag_b[r_cnt] ? {{XLEN{1'b0}}, r_mag_a} : '0);
        end
    end

    assign w_hi = w_acc_nxt[2*XLEN-1:XLEN];
    assign w_lo = w_acc_nxt[XLEN-1:0];

    // High half of a negated 2*XLEN product is -(hi + (lo != 0)), so pre-bias before the shared negate.
    always_comb begin
        w_fin_raw = w_lo;
        case (r_op)
            MD_MULH, MD_MULHSU, MD_MULHU: w_fin_raw = w_hi + {{(XLEN-1){1'b0}}, r_neg & (w_lo != '0)};
            MD_REM, MD_REMU:              w_fin_raw = w_hi;
            default:                      w_fin_raw = w_lo;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= MD_MUL;
            r_word     <= 1'b0;
            r_neg      <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op    <= bus.in_op;
                        r_word  <= bus.in_word;
                        r_neg   <= w_neg_in;
                        r_mag_a <= w_a_mag;
                        r_mag_b <= w_b_mag;
                        r_acc   <= '0;
                        r_cnt   <= bus.in_word ? 6'(WLEN-1) : 6'(XLEN-1);
                        if (w_special) begin
                            r_out_data <= w_fix_out;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == '0) begin
                        r_out_data <= w_fix_out;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = w_done;
    assign bus.out_data  = r_out_data;
    assign bus.stall     = (bus.in_valid & ~w_done) | w_calc;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_seq_if bus();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: extend operands to wide signed integers and use native arithmetic.
    function automatic logic [63:0] ref_model(input muldiv_op_t op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic sa, sb;
        logic signed [129:0] xa, xb, r;
        logic [63:0] res;
        sa = op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        sb = op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        if (w) begin
            xa = sa ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
            xb = sb ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
        end else begin
            xa = sa ? {{66{a[63]}}, a} : {66'b0, a};
            xb = sb ? {{66{b[63]}}, b} : {66'b0, b};
        end
        case (op)
            MD_MUL:                       r = xa * xb;
            MD_MULH, MD_MULHSU, MD_MULHU: r = (xa * xb) >>> 64;
            MD_DIV, MD_DIVU:              r = (xb == 0) ? -130'sd1 : xa / xb;
            default:                      r = (xb == 0) ? xa : xa % xb;
        endcase
        res = r[63:0];
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    // Edges from the accept edge (inclusive) until out_valid is visible.
    function automatic int ref_lat(input muldiv_op_t op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic is_div, sgn, bz, ovf;
        is_div = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        sgn    = op inside {MD_DIV, MD_REM};
        bz     = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf    = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (is_div && (bz || ovf)) return 1;
        return (w ? 32 : 64) + 1;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'(32'($urandom_range(0, 1000)));
            4:       return {32'($urandom), 32'h8000_0000};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic run_op(input muldiv_op_t op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int hold,
                          input string tag);
        int   lat;
        int   exp_lat;
        logic stall_ok;
        logic stable;
        exp_lat = ref_lat(op, w, a, b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_word  = w;
        bus.in_a     = a;
        bus.in_b     = b;
        #1;
        chk({tag, " issue ready/stall"}, {62'd0, bus.in_ready, bus.stall}, 64'd3);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the result must not depend on them.
        bus.in_valid = 1'b0;
        bus.in_op    = muldiv_op_t'(3'($urandom_range(0, 7)));
        bus.in_a     = {32'($urandom), 32'($urandom)};
        bus.in_b     = {32'($urandom), 32'($urandom)};
        lat      = 1;
        stall_ok = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            if (!bus.stall || bus.in_ready) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " stall while busy"}, 64'(stall_ok), 64'd1);
        chk({tag, " result"}, bus.out_data, exp);
        stable = 1'b1;
        if (hold > 0) bus.in_valid = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (bus.out_data !== exp || !bus.out_valid || bus.in_ready) stable = 1'b0;
        end
        chk({tag, " held in DONE"}, 64'(stable), 64'd1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " release valid/ready"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen_valid;
        muldiv_op_t  rop;
        logic        rw;
        logic [63:0] ra, rb;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = MD_MUL;
        bus.in_word   = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset outputs", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        chk("reset out_data", bus.out_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset ready", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

        run_op(MD_MUL,    1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 5, "mul 7*-3");
        run_op(MD_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulhu ones");
        run_op(MD_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, "mulhsu -1*2");
        run_op(MD_DIV,    1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0, "divw ovf");
        run_op(MD_REM,    1'b1, 64'h0000_0000_8000_0000, '1, 64'd0, 0, "remw ovf");
        run_op(MD_DIV,    1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "div by 0");
        run_op(MD_REMU,   1'b0, 64'd100, 64'd0, 64'd100, 2, "remu by 0");
        run_op(MD_REM,    1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, "rem -7%2");
        run_op(MD_REMU,   1'b1, 64'h0000_0000_FFFF_FFF0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 0, "remuw by 0");

        // Flush in cycle T+10 of a DIVU.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = MD_DIVU;
        bus.in_word  = 1'b0;
        bus.in_a     = 64'h1234_5678_9ABC_DEF0;
        bus.in_b     = 64'd13;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush -> idle", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        seen_valid = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            seen_valid |= bus.out_valid;
        end
        chk("flush discards result", 64'(seen_valid), 64'd0);
        run_op(MD_REMU, 1'b1, 64'd10, 64'd3, 64'd1, 0, "remuw after flush");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = MD_MUL;
        bus.in_word  = 1'b0;
        bus.in_a     = 64'd99;
        bus.in_b     = 64'd77;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mid-calc reset flags", {61'd0, bus.out_valid, bus.in_ready, bus.stall}, 64'd2);
        chk("mid-calc reset data", bus.out_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after release", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

        for (int i = 0; i < 40; i++) begin
            rop = muldiv_op_t'(3'($urandom_range(0, 7)));
            rw  = (rop inside {MD_MULH, MD_MULHSU, MD_MULHU}) ? 1'b0 : 1'($urandom_range(0, 1));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, rw, ra, rb, ref_model(rop, rw, ra, rb), $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer beside the execute-stage ALU for the RV64M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus the W forms).
- Accepts one operation from execute using the forwarded src1/src2 values, iterates radix-2, and returns a word_t result.
- Drives the stall that holds execute, and earlier stages, until the result is accepted.
- The pipeline muxes out_data against the ALU output when the decoded control selects muldiv.

Parameters:
XLEN, 64, operand/result width (equals word_t width)

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-low (0 = reset)
in_valid  input  1  execute presents an M-extension op
in_ready  output  1  sequencer can accept (IDLE only)
in_op  input  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
in_word  input  1  W-form (32-bit op, sign-extended result)
in_a  input  XLEN  rs1 value after forwarding
in_b  input  XLEN  rs2 value after forwarding
flush  input  1  kill in-flight op (branch/exception)
out_valid  output  1  result ready
out_ready  input  1  execute/memory consumes result
out_data  output  XLEN  result
stall  output  1  = (in_valid & ~out_valid) | busy-in-CALC

Behaviour:
- States: IDLE, CALC, DONE. Reset (async, level 0): state=IDLE, counter=0, out_valid=0, out_data=0, accumulators=0; in_ready=1 once reset releases.
- IDLE: in_ready=1. Accept on in_valid at an edge. Latch the op, the word flag, and sign-adjusted magnitudes.
- Operand prep:
  - W-form uses a[31:0] and b[31:0], sign- or zero-extended per op signedness.
  - Signed operands are converted to magnitude. The result-negate flag is recorded: product/quotient negate if the signs differ; remainder takes the dividend's sign.
- Iteration count N = 64, or 32 when in_word=1.
- Special cases skip CALC and go to DONE on the next edge:
  - divide by zero: quotient = all ones; remainder = dividend (pre-magnitude value, W-truncated).
  - signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle into a 2N-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - The counter decrements from N-1. At counter=0 the next edge enters DONE, with sign fix applied and the result selected.
- Latency: accept at edge T. Normal op: out_valid=1 from cycle T+N+1. Special case: out_valid=1 from cycle T+1.
- Result selection:
  - MUL: low XLEN bits.
  - MULH*: high XLEN bits.
  - DIV*: quotient.
  - REM*: remainder.
  - W-form: bits [31:0] sign-extended to XLEN (including DIVUW/REMUW).
- DONE: out_valid=1 and out_data held stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid=0 next cycle.
  - in_ready stays 0 in DONE; no back-to-back accept in the same cycle.
- flush (any state): next edge returns to IDLE with out_valid=0. The result is discarded. flush wins over in_valid and out_ready in the same cycle.
- Reset mid-CALC: immediate return to IDLE, all outputs at reset values.
- in_a/in_b/in_op changes after acceptance are ignored.

Decomposition:
- muldiv_op_t enum (3 bits) goes in pipes, beside the control_t fields. A muldiv-select bit is added to control_t.
- The state enum stays local.
- One sub-module is natural: muldiv_signfix, a combinational block for magnitude conversion, result negation, and W sign-extension. It is shared by the prep and finish paths.

Test Plan:
- MUL a=7, b=-3 (64-bit) -> out_valid at T+65, out_data=0xFFFF_FFFF_FFFF_FFEB; stall high T..T+64.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> out_data=0xFFFF_FFFF_FFFF_FFFE; MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> overflow path, out_valid at T+1, out_data=0xFFFF_FFFF_8000_0000; REMW same operands -> 0.
- DIV a=100, b=0 -> out_valid at T+1, 0xFFFF_FFFF_FFFF_FFFF; REMU a=100, b=0 -> 100; REM a=-7, b=2 -> -1 at T+65.
- Start DIVU, assert flush at T+10 -> IDLE at T+11, out_valid never rises, in_ready=1; then REMUW a=10, b=3 -> 1 at T'+33.
- Hold out_ready=0 in DONE for 5 cycles -> out_data stable, in_ready=0; drop reset low mid-CALC -> out_valid=0, in_ready=1 after release.
